// File: rtl/i2c_slave_cfg_parser.sv
// i2c_slave_cfg_parser
//
// Turns framed "set slave config" commands from the USB-CDC receive byte
// stream into the slave address and register-address mode used by the I2C
// slave wrapper. Each frame gets a one-byte status reply on the transmit path.
//
// Frame: 5A, CMD, LEN, LEN payload bytes, CHK
//        CHK = (CMD + LEN + payload bytes) mod 256
//
// Status codes: 00 ok, 01 bad checksum, 02 bad length, 03 reserved address,
//               04 inter-byte timeout.
//
// Ports
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   rx_data / rx_valid  received byte, rx_valid is a single-cycle strobe
//   cfg_slave_address   registered 7-bit slave address
//   cfg_reg_addr_16bit  0 = 8-bit register address, 1 = 16-bit
//   cfg_update          one-cycle pulse when the cfg outputs are rewritten
//   frame_error         one-cycle pulse on any rejected or aborted frame
//   tx_data / tx_valid  status byte and its pending flag
//   tx_ready            downstream accept
//   dbg_state           current parser state (state_t encoding)
//
// Handshake: the status byte transfers on any clock edge where
// tx_valid && tx_ready. tx_data/tx_valid are held stable until then. A newer
// status replaces a pending one (the older is dropped); if the pending one
// is accepted in the same cycle a new one is produced, the new one is loaded
// and tx_valid stays high.
//
// TIMEOUT_CYCLES must be at least 2.

module i2c_slave_cfg_parser #(
  parameter logic [7:0]  CMD_CODE       = 8'h30,
  parameter logic [6:0]  DEFAULT_ADDR   = 7'h50,
  parameter int unsigned MAX_LEN        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] cfg_slave_address,
  output logic       cfg_reg_addr_16bit,
  output logic       cfg_update,
  output logic       frame_error,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_SOF     = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4
  } state_t;

  localparam logic [7:0] SOF_BYTE = 8'h5A;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_CHECKSUM = 8'h01;
  localparam logic [7:0] ST_LENGTH   = 8'h02;
  localparam logic [7:0] ST_ADDRESS  = 8'h03;
  localparam logic [7:0] ST_TIMEOUT  = 8'h04;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter is cleared on the byte edge, so firing while it holds
  // TIMEOUT_CYCLES-2 puts the abort on the edge where it would reach
  // TIMEOUT_CYCLES-1, i.e. TIMEOUT_CYCLES-1 cycles after the last byte.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 2);

  // Parser state
  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [6:0]      p0_q, p0_d;
  logic            p1_q, p1_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;

  // Per-cycle decisions, registered into the outputs below
  logic            status_set;
  logic [7:0]      status_val;
  logic            err_set;
  logic            cfg_set;
  logic            addr_reserved;

  assign dbg_state = state_q;

  // 00-07 and 78-7F are reserved I2C addresses
  assign addr_reserved = (p0_q <= 7'h07) || (p0_q >= 7'h78);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    to_cnt_d   = to_cnt_q;
    status_set = 1'b0;
    status_val = ST_OK;
    err_set    = 1'b0;
    cfg_set    = 1'b0;

    if (rx_valid) begin
      // A byte always beats a timeout that would fire in the same cycle
      to_cnt_d = '0;
      case (state_q)
        S_SOF: begin
          if (rx_data == SOF_BYTE) begin
            state_d = S_CMD;
          end
        end

        S_CMD: begin
          cmd_d   = rx_data;
          sum_d   = rx_data;
          state_d = S_LEN;
        end

        S_LEN: begin
          len_d = rx_data;
          sum_d = sum_q + rx_data;
          cnt_d = '0;
          if (32'(rx_data) > MAX_LEN) begin
            // Error pulses for any command, but only our own gets a reply
            err_set    = 1'b1;
            status_set = (cmd_q == CMD_CODE);
            status_val = ST_LENGTH;
            state_d    = S_SOF;
          end else if (rx_data == 8'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          sum_d = sum_q + rx_data;
          if (cnt_q == 8'd0) begin
            p0_d = rx_data[6:0];
          end
          if (cnt_q == 8'd1) begin
            p1_d = rx_data[0];
          end
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) begin
            state_d = S_CHK;
          end
        end

        S_CHK: begin
          state_d = S_SOF;
          if (rx_data != sum_q) begin
            err_set    = 1'b1;
            status_set = 1'b1;
            status_val = ST_CHECKSUM;
          end else if (cmd_q != CMD_CODE) begin
            // Well-formed frame for another parser: stay silent
            status_set = 1'b0;
          end else if (len_q != 8'd2) begin
            err_set    = 1'b1;
            status_set = 1'b1;
            status_val = ST_LENGTH;
          end else if (addr_reserved) begin
            err_set    = 1'b1;
            status_set = 1'b1;
            status_val = ST_ADDRESS;
          end else begin
            cfg_set    = 1'b1;
            status_set = 1'b1;
            status_val = ST_OK;
          end
        end

        default: begin
          state_d = S_SOF;
        end
      endcase
    end else if (state_q != S_SOF) begin
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d   = '0;
        state_d    = S_SOF;
        err_set    = 1'b1;
        status_set = 1'b1;
        status_val = ST_TIMEOUT;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_SOF;
      cmd_q    <= '0;
      len_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      p0_q     <= '0;
      p1_q     <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      len_q    <= len_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      p0_q     <= p0_d;
      p1_q     <= p1_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Configuration and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_slave_address  <= DEFAULT_ADDR;
      cfg_reg_addr_16bit <= 1'b0;
      cfg_update         <= 1'b0;
      frame_error        <= 1'b0;
      tx_data            <= 8'h00;
      tx_valid           <= 1'b0;
    end else begin
      cfg_update  <= cfg_set;
      frame_error <= err_set;
      if (cfg_set) begin
        cfg_slave_address  <= p0_q;
        cfg_reg_addr_16bit <= p1_q;
      end
      if (status_set) begin
        tx_data  <= status_val;
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/i2c_slave_cfg_parser.md
# i2c_slave_cfg_parser

Configuration front-end for the I2C slave emulator. It consumes the byte stream coming from the USB-CDC receive path, recognises framed "set slave config" commands, validates them, and drives the registered 7-bit slave address and 8/16-bit register-address mode consumed by the I2C slave wrapper. It also returns a one-byte status response to the USB-CDC transmit path.

## Interface
Parameters:
- `CMD_CODE`, `8'h30`: command byte selecting I2C-slave configuration.
- `DEFAULT_ADDR`, `7'h50`: slave address after reset.
- `MAX_LEN`, `8`: largest accepted payload length, in bytes.
- `TIMEOUT_CYCLES`, `5_000_000`: inter-byte timeout, in clk cycles (100 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  single-cycle strobe; `rx_data` is valid this cycle.
- `cfg_slave_address`  out  7  registered slave address.
- `cfg_reg_addr_16bit`  out  1  register-address mode: 0 = 8-bit, 1 = 16-bit.
- `cfg_update`  out  1  one-cycle pulse when the cfg outputs change.
- `frame_error`  out  1  one-cycle pulse on any rejected or aborted frame.
- `tx_data`  out  8  status byte.
- `tx_valid`  out  1  status byte pending.
- `tx_ready`  in  1  downstream accepts `tx_data` when `tx_valid && tx_ready`.

## Operation
- Frame format: SOF `8'h5A`, CMD, LEN, LEN payload bytes, CHK.
  - CHK = (CMD + LEN + all payload bytes) mod 256.
- FSM states: S_SOF, S_CMD, S_LEN, S_PAYLOAD, S_CHK. Transitions happen only on `rx_valid`, except timeout.
- S_SOF:
  - byte `8'h5A` → S_CMD.
  - any other byte is discarded silently.
- S_CMD: latch CMD, start the checksum accumulator at CMD → S_LEN.
- S_LEN:
  - LEN > MAX_LEN → `frame_error`, status `8'h02` (CMD_CODE frames only) → S_SOF.
  - LEN == 0 → S_CHK.
  - otherwise → S_PAYLOAD.
- S_PAYLOAD:
  - Accumulate each byte into the checksum.
  - Store payload bytes 0 and 1 only; discard the rest.
  - A byte counter goes to S_CHK after LEN bytes.
- S_CHK: checks are applied in this order.
  1. Checksum mismatch → status `8'h01`, `frame_error`.
  2. CMD ≠ CMD_CODE → no status, no error; frame ignored because it belongs to another parser.
  3. LEN ≠ 2 → status `8'h02`, `frame_error`.
  4. Address = payload0[6:0] in `7'h00`–`7'h07` or `7'h78`–`7'h7F` → status `8'h03`, `frame_error`.
  5. Otherwise: `cfg_slave_address` ← payload0[6:0], `cfg_reg_addr_16bit` ← payload1[0], `cfg_update` pulse, status `8'h00`.
  - All cases → S_SOF.
- Unused bits are ignored: payload0[7] and payload1[7:1].
- Timeout:
  - The counter clears on every `rx_valid` and counts while the state ≠ S_SOF.
  - Reaching TIMEOUT_CYCLES−1 → `frame_error`, status `8'h04`, → S_SOF.
  - Timeout status is emitted regardless of CMD.
- Status path:
  - `tx_data`/`tx_valid` are held until `tx_ready`.
  - A new status arriving while one is still pending overwrites `tx_data` and keeps `tx_valid` high; the older status is lost.
- Configuration outputs hold their values across all errors. Only a fully valid frame changes them.

## Timing
- Reset values:
  - `cfg_slave_address` = DEFAULT_ADDR, `cfg_reg_addr_16bit` = 0.
  - `cfg_update`, `frame_error`, `tx_valid` = 0; `tx_data` = `8'h00`.
  - State S_SOF, counters 0.
- Config latency: new cfg values and the `cfg_update` pulse appear on the clk edge after the cycle in which the CHK byte's `rx_valid` is high.
- `frame_error` and a new `tx_valid` assert in that same cycle.
- Back-to-back `rx_valid` on every cycle is supported. A SOF byte on the cycle right after CHK is accepted.
- Timeout and `rx_valid` in the same cycle: the byte wins and the counter clears.
- Status handshake: if the pending status is accepted (`tx_valid && tx_ready`) in the same cycle a new status is generated, the new status is loaded and `tx_valid` stays high.
- Reset mid-frame: the FSM returns to S_SOF immediately, the partial frame is lost, and the cfg outputs return to their defaults.

## Test plan
- Valid 8-bit config: send `5A 30 02 3C 00 6E`. Required: `cfg_slave_address` = `7'h3C`, mode 0, one `cfg_update` pulse, `tx_data` = `8'h00`.
- Valid 16-bit config: send `5A 30 02 51 01 84`. Required: address `7'h51`, mode 1, status `8'h00`. Then send the same frame with CHK = `85`. Required: status `8'h01`, `frame_error` pulse, outputs unchanged.
- Reserved address: send `5A 30 02 7A 00 AC`. Required: status `8'h03`, address stays at its previous value.
- Foreign command and bad length:
  - Send `5A 31 01 00 32`. Required: no status, no `frame_error`.
  - Send `5A 30 09`. Required: immediate status `8'h02`.
  - Then send `12 5A 30 02 20 00 52`. Required: the leading `12` is discarded and the config is applied (address `7'h20`).
- Timeout: send `5A 30`, then idle for TIMEOUT_CYCLES (override parameter to 100). Required: `frame_error` and status `8'h04` exactly 99 cycles after the last byte, and a following valid frame is accepted.
- Backpressure and reset:
  - Hold `tx_ready` = 0 across two error frames. Required: `tx_valid` stays high and `tx_data` shows the last status.
  - Assert `rst_n` low mid-payload. Required: all outputs return to reset values.
